// File: rtl/shift_add_square.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_square (with helper cla_16)
// Description : Sequential 16-bit squarer for the threshold-cutter energy
//               path. Accepts one sample over a valid/ready handshake, squares
//               it with 16 shift-and-add iterations through a single 16-bit
//               carry-lookahead adder, then holds the 32-bit result on a
//               second valid/ready handshake until it is taken.
// Ports       : clk       in   1   rising-edge clock
//               rst_n     in   1   asynchronous active-low reset
//               in_valid  in   1   sample available
//               in_ready  out  1   block can accept a sample (IDLE only)
//               in_data   in  16   sample
//               out_valid out  1   result available
//               out_ready in   1   downstream accepts result
//               out_data  out 32   unsigned square of in_data
// Config      : SQUARE_SIGNED_IN_EN defined   -> in_data is two's complement,
//                                                its magnitude is squared
//               SQUARE_SIGNED_IN_EN undefined -> in_data is unsigned
// Revision    : 1.0  initial release
// ============================================================================

// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second lookahead level. g_out is the group generate of the whole word, so
// it is the carry-out whenever c_in is 0.
module cla_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        g_out
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_c;

    assign g = a & b;
    assign p = a ^ b;

    // Second-level lookahead: carry into each 4-bit group.
    assign grp_c[0] = c_in;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & c_in);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_in);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);
    assign g_out    = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_grp
            localparam int B = 4 * k;
            assign c[B]     = grp_c[k];
            assign c[B + 1] = g[B] | (p[B] & grp_c[k]);
            assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & grp_c[k]);
            assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                            | (p[B + 2] & p[B + 1] & p[B] & grp_c[k]);
            assign grp_g[k] = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                            | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
            assign grp_p[k] = &p[B + 3:B];
        end
    endgenerate

    assign s = p ^ c;
endmodule

module shift_add_square (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] m_reg;
    logic [15:0] acc;
    logic [15:0] q_reg;
    logic [4:0]  cnt;
    logic [15:0] sum;
    logic        carry;
    logic [15:0] mag;

`ifdef SQUARE_SIGNED_IN_EN
    // 16-bit negate: -32768 maps to 0x8000, which is its exact magnitude.
    assign mag = in_data[15] ? (~in_data + 16'd1) : in_data;
`else
    assign mag = in_data;
`endif

    cla_16 u_cla (
        .a     (acc),
        .b     (m_reg),
        .c_in  (1'b0),
        .s     (sum),
        .g_out (carry)
    );

    // Handshake outputs are pure state decodes: no input-to-output path.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = {acc, q_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m_reg <= 16'd0;
            acc   <= 16'd0;
            q_reg <= 16'd0;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg <= mag;
                        q_reg <= mag;
                        acc   <= 16'd0;
                        cnt   <= 5'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // {carry, A, Q} >> 1, where A is either the adder sum or
                    // the unchanged accumulator depending on the multiplier LSB.
                    if (q_reg[0]) begin
                        acc   <= {carry, sum[15:1]};
                        q_reg <= {sum[0], q_reg[15:1]};
                    end else begin
                        acc   <= {1'b0, acc[15:1]};
                        q_reg <= {acc[0], q_reg[15:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_shift_add_square.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_square
// Description : Self-checking bench for shift_add_square. Accepted samples
//               push their golden square into a scoreboard queue; transferred
//               results pop and compare. Golden mode follows
//               SQUARE_SIGNED_IN_EN exactly like the design build.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_add_square;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int          checks;
    int          errors;
    int          cyc;
    int          acc_edge;
    int          last_acc_edge;
    int          n_in;
    int          n_out;
    logic        prev_ov;
    logic        rand_ready;
    logic [31:0] sb[$];

    shift_add_square dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] golden(input logic [15:0] x);
        longint v;
`ifdef SQUARE_SIGNED_IN_EN
        v = longint'($signed(x));
        if (v < 0) v = -v;
`else
        v = longint'(x);
`endif
        return 32'(v * v);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Random downstream back-pressure during the sweep.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: sampled mid-cycle; a handshake seen here completes at the next
    // rising edge, whose index is cyc + 1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb.push_back(golden(in_data));
                last_acc_edge = acc_edge;
                acc_edge      = cyc + 1;
                n_in++;
            end
            if (out_valid && !prev_ov)
                check_value("latency", 32'(cyc - acc_edge), 32'd16);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0)
                    check_value("unexpected_result", out_data, 32'hDEAD_BEEF);
                else
                    check_value("result", out_data, sb.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [15:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check_value("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 5000 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        if (i == 5000) check_value("drain_timeout", 32'd0, 32'd1);
    endtask

    int prev_n_out;

    initial begin
        checks = 0; errors = 0; cyc = 0; acc_edge = 0; last_acc_edge = 0;
        n_in = 0; n_out = 0; prev_ov = 1'b0; rand_ready = 1'b0;
        in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        check_value("rst_in_ready", 32'(in_ready), 32'd1);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_out_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single sample: 3*3 with latency check from the monitor.
        send(16'd3);
        check_value("in_ready_drop", 32'(in_ready), 32'd0);
        drain();

        // Sign-mode corner values.
`ifdef SQUARE_SIGNED_IN_EN
        send(16'h8000); drain();
        send(16'hFFFF); drain();
        check_value("signed_min_sq", golden(16'h8000), 32'h4000_0000);
`else
        send(16'hFFFF); drain();
        check_value("unsigned_max_sq", golden(16'hFFFF), 32'hFFFE_0001);
`endif

        // Downstream stall: result must hold, new input must be ignored.
        out_ready = 1'b0;
        send(16'h1234);
        for (int i = 0; i < 40 && !out_valid; i++) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'h0777;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_value("stall_valid", 32'(out_valid), 32'd1);
            check_value("stall_data", out_data, 32'h014B_5A90);
            check_value("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        check_value("no_ghost_result", 32'(out_valid), 32'd0);

        // Back-to-back stream. in_ready is low for 17 cycles per sample
        // (16 iterations + 1 DONE), so accept edges are 18 edges apart.
        prev_n_out = n_out;
        in_data  = 16'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: in_data = 16'd0;
                1: in_data = 16'd1;
                2: in_data = 16'd255;
                default: in_data = 16'h7FFF;
            endcase
            for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
            @(posedge clk); #1;
            if (k > 0) check_value("accept_gap", 32'(acc_edge - last_acc_edge), 32'd18);
        end
        in_valid = 1'b0;
        drain();
        check_value("stream_count", 32'(n_out - prev_n_out), 32'd4);
        check_value("sq_7fff", golden(16'h7FFF), 32'h3FFF_0001);

        // Asynchronous reset in the middle of RUN.
        send(16'd9);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("async_in_ready", 32'(in_ready), 32'd1);
        check_value("async_out_valid", 32'(out_valid), 32'd0);
        check_value("async_out_data", out_data, 32'd0);
        sb.delete();
        n_in--;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'd5);
        drain();

        // Random sweep with input gaps and output back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(16'($urandom()));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        check_value("sb_empty", 32'(sb.size()), 32'd0);
        check_value("in_out_count", 32'(n_out), 32'(n_in));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
